// File: rtl/pio_out_pkg.sv
// pio_out_pkg: register offsets and STATUS bit positions shared by the
// pio_out_stream slave and anything that decodes its status word.
package pio_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_SET    = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_LEVEL_LSB = 8;

endpackage

// File: rtl/pio_out_fifo.sv
// pio_out_fifo: small synchronous FIFO feeding the ready/valid consumer.
// A push while full is accepted only when a pop happens in the same cycle;
// push_ok reports whether the word was taken so the caller can flag overflow.
module pio_out_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pio_out_stream.sv
// pio_out_stream: Avalon-MM output PIO. Writes to DATA drive the level
// register and are queued for a ready/valid consumer; STATUS exposes fill
// level and a sticky overflow flag.
// Optional feature macro: PIO_OUT_SETCLR_EN enables bit set/clear at
// offsets 2 and 3; without it those offsets ignore writes and read as 0.
module pio_out_stream
  import pio_out_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              wr;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] data_q;
  logic              overflow;
  logic [31:0]       rd_next;

  assign wr        = chipselect & ~write_n;
  assign push      = wr & (address == ADDR_DATA);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_port  = data_q;

  pio_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (writedata[DATA_W-1:0]),
    .head    (out_data),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok)
  );

  // DATA level register: full write at offset 0, optional bit set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (push) begin
      data_q <= writedata[DATA_W-1:0];
`ifdef PIO_OUT_SETCLR_EN
    end else if (wr && address == ADDR_SET) begin
      data_q <= data_q | writedata[DATA_W-1:0];
    end else if (wr && address == ADDR_CLEAR) begin
      data_q <= data_q & ~writedata[DATA_W-1:0];
`endif
    end
  end

  // Sticky overflow: set when a DATA write is dropped, cleared via STATUS bit2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end else if (wr && address == ADDR_STATUS && writedata[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Read mux; reads are side-effect free and do not need chipselect.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[DATA_W-1:0] = data_q;
      ADDR_STATUS: begin
        rd_next[ST_EMPTY]             = empty;
        rd_next[ST_FULL]              = full;
        rd_next[ST_OVF]               = overflow;
        rd_next[ST_LEVEL_LSB +: LW]   = level;
      end
      default: rd_next = '0;
    endcase
  end

  // Registered read data gives one cycle of read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_pio_out_stream.sv
// tb_pio_out_stream: directed bench for pio_out_stream with a scoreboard
// queue for the streaming side and direct checks on register reads.
module tb_pio_out_stream;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pio_out_stream #(.DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(posedge clk); #1;
    check(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: any handshake at the negedge must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_unexpected: got 0x%08h expected no word", out_data);
      end else begin
        check("stream_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;

    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Reset state
    bus_rd(2'd1, 32'h0000_0001, "reset_status");
    check("reset_out_port", out_port, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);

    // Fill to full with consumer stalled, then overflow
    for (int i = 0; i < 4; i++) begin
      bus_wr(2'd0, w[i]);
      exp_q.push_back(w[i]);
    end
    bus_rd(2'd1, 32'h0000_0402, "full_status");
    check("full_out_port", out_port, 32'h44);
    check("head_held", out_data, 32'h11);
    bus_wr(2'd0, 32'h55);
    check("ovf_out_port", out_port, 32'h55);
    bus_rd(2'd1, 32'h0000_0406, "ovf_status");
    bus_rd(2'd0, 32'h0000_0055, "data_read");

    // Drain four words back to back
    out_ready = 1'b1;
    idle(4);
    check("drained_valid", {31'b0, out_valid}, 32'h0);
    check("drained_queue", exp_q.size(), 32'd0);
    bus_wr(2'd1, 32'h4);
    bus_rd(2'd1, 32'h0000_0001, "ovf_cleared");

    // Push while full with simultaneous pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_wr(2'd0, 32'hA1 + i);
      exp_q.push_back(32'hA1 + i);
    end
    out_ready = 1'b1;
    exp_q.push_back(32'h66);
    bus_wr(2'd0, 32'h66);
    out_ready = 1'b0;
    bus_rd(2'd1, 32'h0000_0402, "full_pushpop_status");
    out_ready = 1'b1;
    idle(4);
    check("pushpop_drained_valid", {31'b0, out_valid}, 32'h0);
    check("pushpop_queue", exp_q.size(), 32'd0);

    // Set/clear offsets
    out_ready = 1'b0;
    bus_wr(2'd0, 32'hF0);
    exp_q.push_back(32'hF0);
    bus_wr(2'd2, 32'h0F);
`ifdef PIO_OUT_SETCLR_EN
    check("set_out_port", out_port, 32'hFF);
`else
    check("set_out_port", out_port, 32'hF0);
`endif
    bus_wr(2'd3, 32'h3C);
`ifdef PIO_OUT_SETCLR_EN
    check("clr_out_port", out_port, 32'hC3);
    bus_rd(2'd0, 32'h0000_00C3, "setclr_data_read");
`else
    check("clr_out_port", out_port, 32'hF0);
    bus_rd(2'd0, 32'h0000_00F0, "setclr_data_read");
`endif
    bus_rd(2'd1, 32'h0000_0100, "setclr_level");
    bus_rd(2'd2, 32'h0, "set_read_zero");
    bus_rd(2'd3, 32'h0, "clr_read_zero");
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("setclr_queue", exp_q.size(), 32'd0);

    // Mid-stream reset discards queued words
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd0, 32'h3);
    bus_rd(2'd1, 32'h0000_0300, "three_queued");
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_port", out_port, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_rd(2'd1, 32'h0000_0001, "post_reset_status");
    out_ready = 1'b1;
    idle(2);
    check("post_reset_valid", {31'b0, out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
